// File: rtl/mem_data_bus_ctrl.sv
// Data-side bus master behind the MEM stage: turns a single-cycle MEM access into one
// outstanding req/addr_ok/data_ok transaction, stalling MEM and draining flushed responses.
module mem_data_bus_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_sel_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_uncached_i,
  input  logic                  req_cancel_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  data_req_o,
  output logic                  data_wr_o,
  output logic [1:0]            data_size_o,
  output logic [3:0]            data_wstrb_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic                  data_uncached_o,
  input  logic                  data_addr_ok_i,
  input  logic                  data_data_ok_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Returns {legal, size}; only 1, 2 or 4 active lanes form a bus access.
  function automatic logic [2:0] size_decode(input logic [3:0] sel);
    logic [2:0] cnt;
    cnt = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
    case (cnt)
      3'd1:    size_decode = {1'b1, 2'd0};
      3'd2:    size_decode = {1'b1, 2'd1};
      3'd4:    size_decode = {1'b1, 2'd2};
      default: size_decode = 3'b000;
    endcase
  endfunction

  state_t                state_r, next_state_s;
  logic                  wr_r, uncached_r;
  logic [1:0]            size_r;
  logic [3:0]            wstrb_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r, rdata_r;

  logic [2:0]            dec_s;
  logic                  legal_s, issue_s, latch_s, capture_s;
  logic                  stall_s, valid_s, req_s, wr_s, uncached_s;
  logic [1:0]            size_s;
  logic [3:0]            wstrb_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s, rdata_s;

  assign dec_s   = size_decode(req_sel_i);
  assign legal_s = dec_s[2];
  assign issue_s = req_valid_i & ~req_cancel_i & legal_s;

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    next_state_s = state_r;
    latch_s      = 1'b0;
    capture_s    = 1'b0;
    stall_s      = 1'b0;
    valid_s      = 1'b0;
    req_s        = 1'b0;
    wr_s         = wr_r;
    size_s       = size_r;
    wstrb_s      = wstrb_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    uncached_s   = uncached_r;
    rdata_s      = rdata_r;
    case (state_r)
      IDLE: begin
        wr_s       = req_we_i;
        size_s     = dec_s[1:0];
        wstrb_s    = req_we_i ? req_sel_i : 4'b0000;
        addr_s     = req_addr_i;
        wdata_s    = req_wdata_i;
        uncached_s = req_uncached_i;
        req_s      = issue_s;
        stall_s    = issue_s;
        latch_s    = issue_s;
        if (issue_s) begin
          next_state_s = data_addr_ok_i ? RESP : REQ;
        end else if (req_valid_i && !req_cancel_i) begin
          // Malformed lane mask retires immediately without touching the bus.
          valid_s = 1'b1;
          rdata_s = {DATA_WIDTH{1'b0}};
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (data_addr_ok_i) begin
          next_state_s = req_cancel_i ? DRAIN : RESP;
        end else if (req_cancel_i) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = REQ;
        end
      end
      RESP: begin
        stall_s = 1'b1;
        if (data_data_ok_i) begin
          capture_s    = ~req_cancel_i;
          next_state_s = req_cancel_i ? IDLE : DONE;
        end else if (req_cancel_i) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RESP;
        end
      end
      DONE: begin
        valid_s      = 1'b1;
        next_state_s = IDLE;
      end
      DRAIN: begin
        stall_s = req_valid_i;
        if (data_data_ok_i) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register plus request-field and response latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wr_r       <= 1'b0;
      uncached_r <= 1'b0;
      size_r     <= 2'd0;
      wstrb_r    <= 4'b0000;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      rdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (latch_s) begin
        wr_r       <= wr_s;
        uncached_r <= uncached_s;
        size_r     <= size_s;
        wstrb_r    <= wstrb_s;
        addr_r     <= addr_s;
        wdata_r    <= wdata_s;
      end
      if (capture_s) begin
        rdata_r <= wr_r ? {DATA_WIDTH{1'b0}} : data_rdata_i;
      end
    end
  end

  // Reset forces every output low even while MEM still presents a request.
  assign stall_o         = rst & stall_s;
  assign rdata_valid_o   = rst & valid_s;
  assign rdata_o         = rst ? rdata_s : {DATA_WIDTH{1'b0}};
  assign data_req_o      = rst & req_s;
  assign data_wr_o       = rst & wr_s;
  assign data_size_o     = rst ? size_s : 2'd0;
  assign data_wstrb_o    = rst ? wstrb_s : 4'b0000;
  assign data_addr_o     = rst ? addr_s : {ADDR_WIDTH{1'b0}};
  assign data_wdata_o    = rst ? wdata_s : {DATA_WIDTH{1'b0}};
  assign data_uncached_o = rst & uncached_s;

endmodule
